// File: rtl/sevseg_pkg.sv
// -----------------------------------------------------------------------------
// sevseg_pkg
// Shared constants and helpers for the multiplexed seven-segment driver.
//   SEG_TABLE  : active-high {g,f,e,d,c,b,a} glyphs for hex digits 0..F
//   SEG_OFF    : logical (active-high) code with every segment dark
//   hex_to_seg : nibble -> 7-bit glyph
//   lz_mask    : per-digit leading-zero blank mask (digit 0 never blanked)
// -----------------------------------------------------------------------------
package sevseg_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  // Bit i is set when nibble i and every nibble above it (up to digits-1)
  // are zero. Walking from the most significant digit downward keeps a
  // running "everything above is zero" flag.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] data,
                                                    input int digits);
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < digits) begin
        zero_above = zero_above && (data[4*i +: 4] == 4'h0);
        mask[i]    = zero_above && (i != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/sevseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sevseg_scan_driver_if
// Bundles the display-register side (data, dp, blank_lz, load handshake,
// enable) and the pin side (seg, an, frame_tick) of the scan driver.
//   master : the CPU/register side that drives data and load_req
//   slave  : the scan driver itself
// -----------------------------------------------------------------------------
interface sevseg_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic                  enable;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic                  blank_lz;
  logic                  load_req;
  logic                  load_ack;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output enable, data, dp, blank_lz, load_req,
    input  load_ack, seg, an, frame_tick
  );

  modport slave (
    input  enable, data, dp, blank_lz, load_req,
    output load_ack, seg, an, frame_tick
  );
endinterface

// File: rtl/sevseg_decode.sv
// -----------------------------------------------------------------------------
// sevseg_decode
// Combinational glyph decode for the currently selected digit. Output is
// logical (1 = lit); the parent applies board polarity.
//   nib_i   : hex nibble to show
//   dp_i    : decimal point for this digit
//   blank_i : suppress the glyph (leading zero); dp is still passed through
//   seg_o   : {dp, g, f, e, d, c, b, a}
// -----------------------------------------------------------------------------
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_i, blank_i ? SEG_OFF[6:0] : hex_to_seg(nib_i)};

endmodule

// File: rtl/sevseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevseg_scan_driver
// Time-multiplexed driver for DIGITS seven-segment digits sharing one
// segment bus. Each digit owns a slot of DIV clocks; the first BLANK_CYC
// clocks of every slot keep all anodes dark so the segment bus can settle
// on the new glyph without ghosting into the neighbouring digit.
// Display data is copied into a shadow only at a frame boundary (or while
// disabled) so a frame is never drawn from two different register values.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sevseg_scan_driver_if
//           (enable, data, dp, blank_lz, load_req -> load_ack, seg, an,
//            frame_tick); all outputs are registered
// -----------------------------------------------------------------------------
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DIV            = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sevseg_scan_driver_if.slave  bus
);

  localparam int PW    = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     P_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0]     P_BLANK = PW'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  I_LAST  = IDX_W'(DIGITS - 1);

  // Pin-level "everything dark" patterns; XOR with these applies polarity.
  localparam logic [7:0]        SEG_DARK = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_DARK  = {DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]          presc_q, presc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]    sh_data_q, sh_data_d;
  logic [DIGITS-1:0]      sh_dp_q, sh_dp_d;
  logic                   sh_lz_q, sh_lz_d;
  logic [7:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   ack_q, ack_d;
  logic                   tick_q, tick_d;

  logic                   slot_end, frame_end, accept;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic                   cur_blank;
  logic [MAX_DIGITS-1:0]  lz_bits;
  logic [DIGITS-1:0]      an_onehot;
  logic [7:0]             seg_logic;

  // Scan position, load acceptance and next outputs. Outputs are computed
  // from next-state values so the registered pins always reflect the
  // slot/shadow that is current in the same cycle.
  always_comb begin
    slot_end  = bus.enable && (presc_q == P_LAST);
    frame_end = slot_end && (idx_q == I_LAST);

    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (!bus.enable) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (slot_end) begin
      presc_d = '0;
      idx_d   = (idx_q == I_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    accept    = bus.load_req && (frame_end || !bus.enable);
    sh_data_d = accept ? bus.data     : sh_data_q;
    sh_dp_d   = accept ? bus.dp       : sh_dp_q;
    sh_lz_d   = accept ? bus.blank_lz : sh_lz_q;

    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_onehot[i] = (idx_d == IDX_W'(i));
      if (idx_d == IDX_W'(i)) begin
        cur_nib = sh_data_d[4*i +: 4];
        cur_dp  = sh_dp_d[i];
      end
    end

    lz_bits   = lz_mask((4*MAX_DIGITS)'(sh_data_d), DIGITS);
    cur_blank = sh_lz_d && lz_bits[idx_d];

    seg_d  = bus.enable ? (seg_logic ^ SEG_DARK) : SEG_DARK;
    an_d   = (bus.enable && (presc_d >= P_BLANK)) ? (an_onehot ^ AN_DARK) : AN_DARK;
    ack_d  = accept;
    tick_d = frame_end;
  end

  sevseg_decode u_decode (
    .nib_i   (cur_nib),
    .dp_i    (cur_dp),
    .blank_i (cur_blank),
    .seg_o   (seg_logic)
  );

  // Register stage: scan state, shadow and every output pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_lz_q   <= 1'b0;
      seg_q     <= SEG_DARK;
      an_q      <= AN_DARK;
      ack_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_lz_q   <= sh_lz_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      ack_q     <= ack_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_tick = tick_q;

endmodule
